// File: rtl/pcam_pkg.sv
// Shared types for the parametrised CAM: request op encoding and index-width helper.
package pcam_types;

  localparam logic PCAM_READ  = 1'b1;
  localparam logic PCAM_WRITE = 1'b0;

  // Width of an entry index, which is also the width of an LRU age.
  function automatic int pcam_age_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pcam_repl.sv
// Replacement-victim tracker for pcam. PCAM_LRU_EN selects true LRU ages;
// otherwise a round-robin pointer that advances only on eviction.
module pcam_repl
  import pcam_types::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = pcam_age_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             touch_i,
  input  logic [IDX_W-1:0] touch_idx_i,
  input  logic             evict_i,
  output logic [IDX_W-1:0] victim_idx_o
);

`ifdef PCAM_LRU_EN

  logic [IDX_W-1:0] age_q [DEPTH];
  logic [IDX_W-1:0] age_d [DEPTH];
  logic             unused_evict;

  // Eviction is always accompanied by a touch of the victim, so the strobe adds nothing here.
  assign unused_evict = evict_i;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
    end
    if (touch_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (age_q[i] < age_q[touch_idx_i]) begin
          age_d[i] = age_q[i] + IDX_W'(1);
        end
      end
      age_d[touch_idx_i] = '0;
    end
  end

  always_comb begin
    victim_idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_q[i] == IDX_W'(DEPTH - 1)) begin
        victim_idx_o = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= IDX_W'(DEPTH - 1 - i);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

`else

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_d;
  logic             unused_touch;

  assign unused_touch = ^{touch_i, touch_idx_i};

  // DEPTH is a power of two, so the natural wrap of the pointer is the modulo.
  assign rr_d         = evict_i ? rr_q + IDX_W'(1) : rr_q;
  assign victim_idx_o = rr_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

`endif

endmodule

// File: rtl/pcam.sv
// Parametrised key/value CAM with registered lookup; victim policy chosen by PCAM_LRU_EN
// (defined: true LRU, undefined: round-robin) inside pcam_repl.
module pcam
  import pcam_types::*;
#(
  parameter int KEY_W = 16,
  parameter int VAL_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       valid_i,
  input  logic                       rw_n_i,
  input  logic [KEY_W-1:0]           key_i,
  input  logic [VAL_W-1:0]           val_i,
  output logic [VAL_W-1:0]           val_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int IDX_W = pcam_age_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [VAL_W-1:0] val_t;

  logic [DEPTH-1:0] valid_q;
  key_t             key_q [DEPTH];
  val_t             val_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  val_t             val_o_q;
  logic             valid_o_q;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             has_free;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] victim_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             is_rd;
  logic             is_wr;
  logic             rd_hit;
  logic             do_fill;
  logic             do_evict;
  logic             touch;
  logic [IDX_W-1:0] touch_idx;

  // Writes keep keys unique, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (key_q[i] == key_i)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign is_rd     = valid_i && (rw_n_i == PCAM_READ);
  assign is_wr     = valid_i && (rw_n_i == PCAM_WRITE);
  assign rd_hit    = is_rd && hit;
  assign do_fill   = is_wr && !hit && has_free;
  assign do_evict  = is_wr && !hit && !has_free;
  assign wr_idx    = hit ? hit_idx : (has_free ? free_idx : victim_idx);
  assign touch     = rd_hit || is_wr;
  assign touch_idx = is_wr ? wr_idx : hit_idx;

  pcam_repl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_repl (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .touch_i      (touch),
    .touch_idx_i  (touch_idx),
    .evict_i      (do_evict),
    .victim_idx_o (victim_idx)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q   <= '0;
      count_q   <= '0;
      val_o_q   <= '0;
      valid_o_q <= 1'b0;
    end else begin
      if (do_fill) begin
        valid_q[free_idx] <= 1'b1;
        count_q           <= count_q + CNT_W'(1);
      end
      valid_o_q <= rd_hit;
      val_o_q   <= rd_hit ? val_q[hit_idx] : '0;
    end
  end

  // Key/value payload is only meaningful behind a valid bit, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (is_wr) begin
      key_q[wr_idx] <= key_i;
      val_q[wr_idx] <= val_i;
    end
  end

  assign val_o   = val_o_q;
  assign valid_o = valid_o_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_pcam.sv
// Directed bench for pcam (DEPTH=4) with a recency-list/pointer reference model.
module tb_pcam;

  localparam int DEPTH = 4;
  localparam int KW    = 16;
  localparam int VW    = 16;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          valid_i;
  logic          rw_n_i;
  logic [KW-1:0] key_i;
  logic [VW-1:0] val_i;
  logic [VW-1:0] val_o;
  logic          valid_o;
  logic [2:0]    count_o;

  pcam #(.KEY_W(KW), .VAL_W(VW), .DEPTH(DEPTH)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .valid_i   (valid_i),
    .rw_n_i    (rw_n_i),
    .key_i     (key_i),
    .val_i     (val_i),
    .val_o     (val_o),
    .valid_o   (valid_o),
    .count_o   (count_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: slots, a most-recent-first order list, and a round-robin pointer.
  bit            m_v   [DEPTH];
  logic [KW-1:0] m_k   [DEPTH];
  logic [VW-1:0] m_d   [DEPTH];
  int            order [$];
  int            rr;
  int            victims [$];
  logic [VW-1:0] exp_val;
  logic          exp_valid;
  int            exp_count;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    order = {};
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 0;
      order.push_back(DEPTH - 1 - i);
    end
    rr = 0;
    exp_val = '0;
    exp_valid = 1'b0;
    exp_count = 0;
  endtask

  task automatic touch(input int idx);
    for (int j = 0; j < order.size(); j++) begin
      if (order[j] == idx) begin
        order.delete(j);
        break;
      end
    end
    order.push_front(idx);
  endtask

  task automatic model_step(input logic v, input logic rw, input logic [KW-1:0] k,
                            input logic [VW-1:0] d);
    int hit_i;
    int slot;
    hit_i = -1;
    for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_k[i] == k) hit_i = i;
    exp_val   = '0;
    exp_valid = 1'b0;
    if (v && rw) begin
      if (hit_i >= 0) begin
        exp_val   = m_d[hit_i];
        exp_valid = 1'b1;
        touch(hit_i);
      end
    end else if (v) begin
      slot = -1;
      if (hit_i >= 0) slot = hit_i;
      else begin
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) slot = i;
        if (slot < 0) begin
`ifdef PCAM_LRU_EN
          slot = order[order.size() - 1];
`else
          slot = rr;
          rr = (rr + 1) % DEPTH;
`endif
          victims.push_back(slot);
        end
      end
      m_v[slot] = 1;
      m_k[slot] = k;
      m_d[slot] = d;
      touch(slot);
    end
    exp_count = 0;
    for (int i = 0; i < DEPTH; i++) if (m_v[i]) exp_count++;
  endtask

  // One request per cycle; outputs checked 1 time unit after the edge that produced them.
  task automatic step(input logic v, input logic rw, input logic [KW-1:0] k,
                      input logic [VW-1:0] d);
    valid_i = v;
    rw_n_i  = rw;
    key_i   = k;
    val_i   = d;
    model_step(v, rw, k, d);
    @(posedge clk_i);
    #1;
    chk("valid_o", valid_o, exp_valid);
    chk("val_o", val_o, exp_val);
    chk("count_o", count_o, exp_count);
  endtask

  task automatic wr(input logic [KW-1:0] k, input logic [VW-1:0] d);
    step(1'b1, 1'b0, k, d);
  endtask

  task automatic rd(input logic [KW-1:0] k);
    step(1'b1, 1'b1, k, '0);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    valid_i   = 1'b0;
    model_reset();
    #12;
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    valid_i = 1'b0; rw_n_i = 1'b1; key_i = '0; val_i = '0;
    do_reset();
    chk("reset valid_o", valid_o, 0);
    chk("reset count_o", count_o, 0);

    rd(16'h0001);
    chk("empty read lit", {valid_o, val_o}, 17'h0);

    wr(16'h0001, 16'hAAAA);
    rd(16'h0001);
    chk("read after write lit", {valid_o, val_o, 1'b0, count_o}, {1'b1, 16'hAAAA, 4'd1});

    wr(16'h0001, 16'hBBBB);
    rd(16'h0001);
    chk("update lit", {valid_o, val_o, 1'b0, count_o}, {1'b1, 16'hBBBB, 4'd1});
    step(1'b0, 1'b1, 16'h0001, '0);
    chk("idle clears valid_o", valid_o, 0);

    // Fill, touch key 1, then force one eviction.
    do_reset();
    for (int k = 1; k <= 4; k++) wr(KW'(k), VW'(16'h1000 + k));
    rd(16'h0001);
    wr(16'h0005, 16'h1005);
    chk("count full lit", count_o, 4);
    rd(16'h0002);
`ifdef PCAM_LRU_EN
    chk("lru key2 evicted", valid_o, 0);
`else
    chk("rr key2 kept", {valid_o, val_o}, {1'b1, 16'h1002});
`endif
    rd(16'h0001);
`ifdef PCAM_LRU_EN
    chk("lru key1 kept", {valid_o, val_o}, {1'b1, 16'h1001});
`else
    chk("rr key1 evicted", valid_o, 0);
`endif
    rd(16'h0005);
    chk("key5 present", {valid_o, val_o}, {1'b1, 16'h1005});

    // Pointer wrap: with no reads both policies evict slots 0,1,2,3,0.
    do_reset();
    victims = {};
    for (int k = 1; k <= 4; k++) wr(KW'(k), VW'(16'h2000 + k));
    for (int k = 5; k <= 9; k++) wr(KW'(k), VW'(16'h2000 + k));
    chk("victim count", victims.size(), 5);
    for (int i = 0; i < 5; i++) chk("victim seq", victims[i], (i == 4) ? 0 : i);
    chk("count stays 4", count_o, 4);
    rd(16'h0005);
    chk("key5 overwritten", valid_o, 0);
    rd(16'h0006);
    chk("key6 live", {valid_o, val_o}, {1'b1, 16'h2006});
    rd(16'h0009);
    chk("key9 live", {valid_o, val_o}, {1'b1, 16'h2009});
    wr(16'h0009, 16'h3009);
    wr(16'h000A, 16'h300A);
    rd(16'h0009);
    rd(16'h000A);
    step(1'b0, 1'b0, 16'h0000, '0);

    // Asynchronous reset in the middle of a read hit.
    rd(16'h0006);
    rd(16'h000A);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("async valid_o", valid_o, 0);
    chk("async val_o", val_o, 0);
    chk("async count_o", count_o, 0);
    model_reset();
    @(posedge clk_i);
    #2;
    reset_n_i = 1'b1;
    rd(16'h000A);
    rd(16'h0006);
    rd(16'h0001);
    chk("post reset miss lit", {valid_o, count_o}, 4'h0);
    wr(16'h0042, 16'h4242);
    rd(16'h0042);
    chk("post reset insert lit", {valid_o, val_o}, {1'b1, 16'h4242});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
